// File: rtl/medfilt_pkg.sv
// Shared types and constants for the median-filter stimulus generator.
package medfilt_pkg;

   typedef enum logic [1:0] {
      CONST  = 2'd0,
      RAMP   = 2'd1,
      LFSR   = 2'd2,
      SQUARE = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [15:0] LFSR_POLY         = 16'hB400;
   localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

   // One step of the right-shifting Galois LFSR.
   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return cur[0] ? ((cur >> 1) ^ LFSR_POLY) : (cur >> 1);
   endfunction

endpackage

// File: rtl/medfilt_lfsr16.sv
// 16-bit Galois LFSR with synchronous reseed; load wins over advance.
module medfilt_lfsr16
   import medfilt_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        adv,
   output logic [15:0] q
);

   // Reseed on reset or load, otherwise step once per advance request.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      if (rst || load) begin
         q <= seed;
      end else if (adv) begin
         q <= lfsr_next(q);
      end
   end

endmodule

// File: rtl/medfilt_stim_gen.sv
// Burst sample source (const / ramp / LFSR / square) with optional impulses.
module medfilt_stim_gen
   import medfilt_pkg::*;
#(
   parameter int          N     = 8,
   parameter int          LEN_W = 8,
   parameter logic [15:0] SEED  = LFSR_SEED_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [N-1:0]     base,
   input  logic [N-1:0]     step,
   input  logic [LEN_W-1:0] len,
   input  logic             imp_en,
   input  logic [3:0]       imp_per,
   output logic [N-1:0]     sample,
   output logic             sample_valid,
   output logic             busy,
   output logic             done
);

   localparam logic [N-1:0] IMP_MAX = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] IMP_MIN = {1'b1, {(N-1){1'b0}}};

   state_t           state, state_nxt;
   mode_t            cfg_mode;
   logic [N-1:0]     cfg_base, cfg_step, ramp_acc;
   logic [LEN_W-1:0] cfg_len, k, len_m1;
   logic             cfg_imp_on, imp_pol;
   logic [3:0]       cfg_per, imp_cnt;
   logic             accept, emit, is_imp;
   logic [N-1:0]     base_val, sample_nxt;
   logic [15:0]      lfsr_q;
   logic             lfsr_unused;

   // Only the low N bits feed the sample; fold the rest so nothing dangles.
   assign lfsr_unused = ^lfsr_q;

   medfilt_lfsr16 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (accept),
      .seed (SEED),
      .adv  (emit),
      .q    (lfsr_q)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   assign len_m1 = cfg_len - LEN_W'(1);

   // Next-state decode; len of 0 wraps len_m1 to all-ones, giving 2^LEN_W samples.
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      state_nxt = state;
      accept    = 1'b0;
      emit      = 1'b0;
      unique case (state)
         IDLE: if (start) begin
            accept    = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            emit = 1'b1;
            if (k == len_m1) state_nxt = FIN;
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Per-sample waveform value, then impulse substitution on every P-th sample.
   always_comb begin
      base_val = cfg_base;
      unique case (cfg_mode)
         CONST:  base_val = cfg_base;
         RAMP:   base_val = ramp_acc;
         LFSR:   base_val = lfsr_q[N-1:0];
         SQUARE: base_val = k[0] ? (~cfg_base + N'(1)) : cfg_base;
      endcase
      is_imp     = cfg_imp_on && (imp_cnt == cfg_per - 4'd1);
      sample_nxt = is_imp ? (imp_pol ? IMP_MIN : IMP_MAX) : base_val;
   end

   // Configuration latch, burst counters and the registered output stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_mode     <= CONST;
         cfg_base     <= '0;
         cfg_step     <= '0;
         cfg_len      <= '0;
         cfg_imp_on   <= 1'b0;
         cfg_per      <= '0;
         k            <= '0;
         ramp_acc     <= '0;
         imp_cnt      <= '0;
         imp_pol      <= 1'b0;
         sample       <= '0;
         sample_valid <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         sample       <= emit ? sample_nxt : '0;
         sample_valid <= emit;
         busy         <= emit;
         done         <= (state == FIN);
         if (accept) begin
            cfg_mode   <= mode_t'(mode);
            cfg_base   <= base;
            cfg_step   <= step;
            cfg_len    <= len;
            cfg_imp_on <= imp_en && (imp_per != 4'd0);
            cfg_per    <= imp_per;
            k          <= '0;
            ramp_acc   <= base;
            imp_cnt    <= '0;
            imp_pol    <= 1'b0;
         end else if (emit) begin
            k        <= k + LEN_W'(1);
            ramp_acc <= ramp_acc + cfg_step;
            if (is_imp) begin
               imp_cnt <= '0;
               imp_pol <= ~imp_pol;
            end else begin
               imp_cnt <= imp_cnt + 4'd1;
            end
         end
      end
   end

endmodule
